// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage MIPS pipeline: detects hazards that
// forwarding cannot cover, freezes PC/IF-ID, injects ID/EX bubbles, counts stalls.
module hazard_stall_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  IFIdRs,
  input  logic [4:0]  IFIdRt,
  input  logic [5:0]  IFIdOp,
  input  logic        IDExMemRead,
  input  logic        IDExRegWrite,
  input  logic [4:0]  IDExWr,
  input  logic        ExMemMemRead,
  input  logic [4:0]  ExMemWr,
  input  logic        branchTaken,
  input  logic        jump,
  output logic        pcWrite,
  output logic        ifIdWrite,
  output logic        ctrlFlush,
  output logic        ifIdFlush,
  output logic        stalled,
  output logic [15:0] stallCycles
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        use_rs, use_rt, is_branch;
  logic        hit_ex, hit_mem;
  logic [1:0]  need;
  logic        stall;

  // Hazard detection; forced off while reset is held.
  always_comb begin
    use_rs    = !(IFIdOp == OP_J || IFIdOp == OP_JAL);
    use_rt    = (IFIdOp == OP_RTYPE) || (IFIdOp == OP_BEQ) ||
                (IFIdOp == OP_BNE)   || (IFIdOp == OP_SW);
    is_branch = (IFIdOp == OP_BEQ) || (IFIdOp == OP_BNE);
    hit_ex    = (IDExWr != 5'd0) &&
                ((use_rs && IFIdRs == IDExWr) || (use_rt && IFIdRt == IDExWr));
    hit_mem   = (ExMemWr != 5'd0) &&
                ((use_rs && IFIdRs == ExMemWr) || (use_rt && IFIdRt == ExMemWr));
    need = 2'd0;
    if (rst) begin
      if (IDExMemRead && hit_ex)
        need = is_branch ? 2'd2 : 2'd1;
      else if (is_branch && ((IDExRegWrite && hit_ex) || (ExMemMemRead && hit_mem)))
        need = 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // HOLD ignores detection so a load->branch pair always gets two bubbles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        stall = (need != 2'd0);
        if (need == 2'd2) begin
          state_d = HOLD;
          cnt_d   = 2'd1;
        end
      end
      HOLD: begin
        stall = 1'b1;
        cnt_d = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  assign stalled   = rst && stall;
  assign pcWrite   = !stalled;
  assign ifIdWrite = !stalled;
  assign ctrlFlush = stalled;
  // A pending stall means the branch compare used stale operands: no flush.
  assign ifIdFlush = rst && !stalled && (branchTaken || jump);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stallCycles <= 16'd0;
    else if (stalled && stallCycles != 16'hFFFF)
      stallCycles <= stallCycles + 16'd1;
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed cases with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_hazard_stall_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  IFIdRs = '0, IFIdRt = '0, IDExWr = '0, ExMemWr = '0;
  logic [5:0]  IFIdOp = '0;
  logic        IDExMemRead = 0, IDExRegWrite = 0, ExMemMemRead = 0;
  logic        branchTaken = 0, jump = 0;
  logic        pcWrite, ifIdWrite, ctrlFlush, ifIdFlush, stalled;
  logic [15:0] stallCycles;

  int checks = 0, errors = 0;
  bit chk_en = 0;

  hazard_stall_unit dut (
    .clk(clk), .rst(rst), .IFIdRs(IFIdRs), .IFIdRt(IFIdRt), .IFIdOp(IFIdOp),
    .IDExMemRead(IDExMemRead), .IDExRegWrite(IDExRegWrite), .IDExWr(IDExWr),
    .ExMemMemRead(ExMemMemRead), .ExMemWr(ExMemWr), .branchTaken(branchTaken),
    .jump(jump), .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .ctrlFlush(ctrlFlush),
    .ifIdFlush(ifIdFlush), .stalled(stalled), .stallCycles(stallCycles));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stall cycles the ID instruction needs, straight from the hazard rules.
  function automatic int need_f();
    bit urs, urt, br, mex, mmem;
    int n;
    urs  = !(IFIdOp == 6'd2 || IFIdOp == 6'd3);
    urt  = (IFIdOp == 6'd0 || IFIdOp == 6'd4 || IFIdOp == 6'd5 || IFIdOp == 6'd43);
    br   = (IFIdOp == 6'd4 || IFIdOp == 6'd5);
    mex  = IDExWr != 0 && ((urs && IFIdRs == IDExWr) || (urt && IFIdRt == IDExWr));
    mmem = ExMemWr != 0 && ((urs && IFIdRs == ExMemWr) || (urt && IFIdRt == ExMemWr));
    n = 0;
    if (IDExMemRead && mex) n = br ? 2 : 1;
    if (br && IDExRegWrite && !IDExMemRead && mex && n < 1) n = 1;
    if (br && ExMemMemRead && mmem && n < 1) n = 1;
    return n;
  endfunction

  // Model state: forced stall cycles still owed, and the stall tally.
  int m_hold = 0;
  int m_cnt  = 0;

  function automatic bit m_stall();
    return rst && (m_hold > 0 || need_f() > 0);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_hold <= 0;
      m_cnt  <= 0;
    end else begin
      if (m_stall() && m_cnt < 65535) m_cnt <= m_cnt + 1;
      if (m_hold > 0) m_hold <= m_hold - 1;
      else if (need_f() == 2) m_hold <= 1;
    end
  end

  always @(negedge clk) if (chk_en) begin
    bit s;
    s = m_stall();
    chk("stalled",     stalled,     s);
    chk("pcWrite",     pcWrite,     !s);
    chk("ifIdWrite",   ifIdWrite,   !s);
    chk("ctrlFlush",   ctrlFlush,   s);
    chk("ifIdFlush",   ifIdFlush,   rst && !s && (branchTaken || jump));
    chk("stallCycles", stallCycles, m_cnt);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_in();
    IFIdRs = 0; IFIdRt = 0; IFIdOp = 0; IDExMemRead = 0; IDExRegWrite = 0;
    IDExWr = 0; ExMemMemRead = 0; ExMemWr = 0; branchTaken = 0; jump = 0;
  endtask

  // Leaves time at posedge+4 with reset released.
  task automatic do_reset();
    clear_in();
    @(posedge clk); #2 rst = 0;
    #1;
    chk("rst_stalled", stalled, 0);
    chk("rst_pcWrite", pcWrite, 1);
    chk("rst_count",   stallCycles, 0);
    #1 rst = 1;
  endtask

  task automatic load_beq();
    IDExMemRead = 1; IDExWr = 3; IFIdOp = 6'b000100; IFIdRt = 3; IFIdRs = 1;
    branchTaken = 1;
  endtask

  logic [5:0] ops [8] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd35, 6'd43, 6'd8};

  initial begin
    do_reset();
    chk_en = 1;

    // load-use on R-type
    IDExMemRead = 1; IDExWr = 8; IFIdOp = 0; IFIdRs = 8;
    #2;
    chk("lu_pcWrite", pcWrite, 0);
    chk("lu_ifIdWrite", ifIdWrite, 0);
    chk("lu_ctrlFlush", ctrlFlush, 1);
    tick(); clear_in(); #2;
    chk("lu_release", pcWrite, 1);
    chk("lu_ctrl_off", ctrlFlush, 0);
    chk("lu_count", stallCycles, 1);

    // register 0 and unused rt
    tick(); IDExMemRead = 1; IDExWr = 0; IFIdRs = 0; #2;
    chk("r0_nostall", stalled, 0);
    tick(); IFIdOp = 6'b100011; IFIdRt = 5; IDExWr = 5; IFIdRs = 1; #2;
    chk("lw_rt_nostall", stalled, 0);

    // load then beq: two stalls, no flush despite branchTaken
    do_reset(); load_beq(); #2;
    chk("lb_stall1", stalled, 1);
    chk("lb_flush1", ifIdFlush, 0);
    tick(); clear_in(); branchTaken = 1; #2;
    chk("lb_stall2", stalled, 1);
    chk("lb_flush2", ifIdFlush, 0);
    tick(); #2;
    chk("lb_release", stalled, 0);
    chk("lb_flush3", ifIdFlush, 1);
    chk("lb_count", stallCycles, 2);

    // ALU then bne
    do_reset();
    IDExRegWrite = 1; IDExWr = 9; IFIdOp = 6'b000101; IFIdRs = 9; IFIdRt = 1; #2;
    chk("ab_stall", stalled, 1);
    tick(); clear_in(); branchTaken = 1; #2;
    chk("ab_flush", ifIdFlush, 1);
    chk("ab_pcWrite", pcWrite, 1);
    chk("ab_count", stallCycles, 1);

    // reset mid-HOLD
    do_reset(); load_beq();
    tick(); #2 rst = 0;
    #1;
    chk("mh_stalled", stalled, 0);
    chk("mh_pcWrite", pcWrite, 1);
    chk("mh_ctrlFlush", ctrlFlush, 0);
    chk("mh_ifIdFlush", ifIdFlush, 0);
    chk("mh_count", stallCycles, 0);
    clear_in();
    #1 rst = 1;
    tick(); #2;
    chk("mh_no_residual", stalled, 0);

    // saturation
    do_reset();
    IDExMemRead = 1; IDExWr = 8; IFIdOp = 0; IFIdRs = 8;
    repeat (65540) tick();
    #2;
    chk("sat_count", stallCycles, 16'hFFFF);
    chk("sat_stalled", stalled, 1);

    // randomized traffic; small register range keeps hazards frequent
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      tick();
      IFIdOp       = ops[$urandom_range(0, 7)];
      IFIdRs       = 5'($urandom_range(0, 3));
      IFIdRt       = 5'($urandom_range(0, 3));
      IDExWr       = 5'($urandom_range(0, 3));
      ExMemWr      = 5'($urandom_range(0, 3));
      IDExMemRead  = 1'($urandom_range(0, 1));
      IDExRegWrite = 1'($urandom_range(0, 1));
      ExMemMemRead = 1'($urandom_range(0, 1));
      branchTaken  = 1'($urandom_range(0, 1));
      jump         = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) begin
        #1 rst = 0;
        #1 rst = 1;
      end
    end

    tick();
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
